// File: rtl/popcount_unary_tx.sv
// Count-to-unary transmitter: serialises an N-bit frame whose weight equals the accepted count.
// Define POPCOUNT_UNARY_SHUFFLE_EN to spread the ones with an LFSR instead of a thermometer code.
//
// state  | meaning
// S_IDLE | cnt_ready high, waiting for a count
// S_EMIT | presenting frame bits on the serial handshake
// S_DONE | one cycle: vec_out updated, vec_valid pulsed
module popcount_unary_tx #(
   parameter int              N    = 10,
   parameter int              CW   = 4,
   parameter logic [15:0]     SEED = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] cnt_in,
   input  logic          cnt_valid,
   output logic          cnt_ready,
   output logic          bit_out,
   output logic          bit_valid,
   output logic          bit_last,
   input  logic          bit_ready,
   output logic [N-1:0]  vec_out,
   output logic          vec_valid,
   output logic          sat
);

   typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

   localparam logic [CW-1:0] N_CW = CW'(N);

   state_t        state, state_nxt;
   logic [CW-1:0] ones, ones_nxt;
   logic [CW-1:0] slots, slots_nxt;
   logic [N-1:0]  frame, frame_nxt;
   logic          accept, bit_hs;
   logic          pick_nxt, bit_nxt;

   assign accept = cnt_valid & cnt_ready;
   assign bit_hs = bit_valid & bit_ready;

`ifdef POPCOUNT_UNARY_SHUFFLE_EN
   logic [15:0] lfsr, lfsr_nxt;

   // x^16+x^14+x^13+x^11+1, stepped once per accepted bit
   always_comb begin
      lfsr_nxt = lfsr;
      if (bit_hs)
         lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lfsr <= SEED;
      else     lfsr <= lfsr_nxt;
   end

   assign pick_nxt = lfsr_nxt[0];
`else
   wire unused_seed = ^SEED;
   assign pick_nxt = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      ones_nxt  = ones;
      slots_nxt = slots;
      frame_nxt = frame;
      case (state)
         S_IDLE: begin
            if (accept) begin
               state_nxt = S_EMIT;
               ones_nxt  = (cnt_in > N_CW) ? N_CW : cnt_in;
               slots_nxt = N_CW;
               frame_nxt = '0;
            end
         end
         S_EMIT: begin
            if (bit_hs) begin
               // shift in from the top so the first emitted bit ends at index 0
               frame_nxt = {bit_out, frame[N-1:1]};
               slots_nxt = slots - 1'b1;
               ones_nxt  = ones - CW'(bit_out);
               if (slots == 1) state_nxt = S_DONE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // forced 0 / forced 1 keep the weight exact whatever the pick source
   always_comb begin
      bit_nxt = pick_nxt;
      if (ones_nxt == '0)           bit_nxt = 1'b0;
      else if (ones_nxt == slots_nxt) bit_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ones      <= '0;
         slots     <= '0;
         frame     <= '0;
         cnt_ready <= 1'b0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         bit_last  <= 1'b0;
         vec_out   <= '0;
         vec_valid <= 1'b0;
         sat       <= 1'b0;
      end else begin
         state     <= state_nxt;
         ones      <= ones_nxt;
         slots     <= slots_nxt;
         frame     <= frame_nxt;
         cnt_ready <= (state_nxt == S_IDLE);
         bit_valid <= (state_nxt == S_EMIT);
         bit_out   <= (state_nxt == S_EMIT) & bit_nxt;
         bit_last  <= (state_nxt == S_EMIT) && (slots_nxt == 1);
         vec_valid <= (state_nxt == S_DONE);
         if (state == S_EMIT && state_nxt == S_DONE) vec_out <= frame_nxt;
         if (accept) sat <= (cnt_in > N_CW);
      end
   end

endmodule

// File: tb/tb_popcount_unary_tx.sv
// Randomised self-checking bench for popcount_unary_tx against a count/weight reference model.
module tb_popcount_unary_tx;
   localparam int N  = 10;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [CW-1:0] cnt_in = '0;
   logic          cnt_valid = 1'b0;
   logic          cnt_ready;
   logic          bit_out, bit_valid, bit_last;
   logic          bit_ready = 1'b0;
   logic [N-1:0]  vec_out;
   logic          vec_valid;
   logic          sat;

   int  n_chk = 0;
   int  n_err = 0;
   time t_acc = 0;
   time t_prev_acc = 0;

   popcount_unary_tx #(.N(N), .CW(CW), .SEED(16'hACE1)) dut (
      .clk(clk), .rst(rst),
      .cnt_in(cnt_in), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
      .bit_out(bit_out), .bit_valid(bit_valid), .bit_last(bit_last), .bit_ready(bit_ready),
      .vec_out(vec_out), .vec_valid(vec_valid), .sat(sat)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] thermo(input int w);
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) if (i < w) v[i] = 1'b1;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_cnt_ready", cnt_ready, 0);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_bit_last",  bit_last,  0);
      chk("rst_bit_out",   bit_out,   0);
      chk("rst_vec_out",   vec_out,   0);
      chk("rst_vec_valid", vec_valid, 0);
      chk("rst_sat",       sat,       0);
      @(negedge clk);
      rst = 1'b0;
      bit_ready = 1'b1;
      chk("rel_cnt_ready_low", cnt_ready, 0);
      @(negedge clk);
      chk("rel_cnt_ready_high", cnt_ready, 1);
      chk("rel_vec_valid", vec_valid, 0);
      chk("rel_bit_valid", bit_valid, 0);
   endtask

   task automatic start_frame(input int c);
      int w = 0;
      cnt_in = CW'(c);
      cnt_valid = 1'b1;
      while (!cnt_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("accept_wait", (w < 100), 1);
      @(posedge clk);
      t_prev_acc = t_acc;
      t_acc = $time;
      @(negedge clk);
      cnt_valid = 1'b0;
      cnt_in = CW'($urandom_range(15));
      chk("cnt_ready_busy", cnt_ready, 0);
   endtask

   task automatic send(input int c, input int ready_pct, output logic [N-1:0] vec);
      int           w;
      int           k = 0;
      int           guard = 0;
      logic         prev_stall = 1'b0;
      logic         prev_bit = 1'b0;
      logic [N-1:0] qv = '0;
      w = (c > N) ? N : c;
      start_frame(c);
      while (k < N && guard < 2000) begin
         chk("bit_valid", bit_valid, 1);
         chk("vec_valid_early", vec_valid, 0);
         if (prev_stall) chk("stall_hold", bit_out, prev_bit);
         bit_ready = ($urandom_range(99) < ready_pct);
         if (bit_ready) begin
            qv[k] = bit_out;
            chk("bit_last", bit_last, (k == N-1));
            k++;
            prev_stall = 1'b0;
         end else begin
            prev_stall = 1'b1;
         end
         prev_bit = bit_out;
         guard++;
         @(negedge clk);
      end
      chk("frame_bits", k, N);
      chk("vec_valid", vec_valid, 1);
      chk("bit_valid_done", bit_valid, 0);
      chk("vec_out_order", vec_out, qv);
      chk("weight", $countones(qv), w);
      chk("sat", sat, (c > N));
`ifndef POPCOUNT_UNARY_SHUFFLE_EN
      chk("vec_out_thermo", vec_out, thermo(w));
`endif
      if (ready_pct == 100) chk("latency", int'(($time - t_acc - 5) / 10), N);
      vec = qv;
      @(negedge clk);
      chk("vec_valid_pulse", vec_valid, 0);
      chk("cnt_ready_back", cnt_ready, 1);
      chk("vec_out_hold", vec_out, qv);
   endtask

`ifdef POPCOUNT_UNARY_SHUFFLE_EN
   int           cnts [1000];
   logic [N-1:0] v1 [1000];
`endif

   initial begin
      logic [N-1:0] v;
      int           c;
      do_reset();

      send(4, 100, v);
      send(0, 100, v);
      send(10, 100, v);
      chk("spacing", int'((t_acc - t_prev_acc) / 10), N + 2);
      send(13, 100, v);
      send(6, 50, v);
      for (int i = 0; i < 10; i++) begin
         c = $urandom_range(15);
         send(c, $urandom_range(100, 30), v);
      end

      start_frame(7);
      bit_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_cnt_ready", cnt_ready, 0);
      chk("mid_bit_valid", bit_valid, 0);
      chk("mid_bit_out",   bit_out,   0);
      chk("mid_bit_last",  bit_last,  0);
      chk("mid_vec_out",   vec_out,   0);
      chk("mid_vec_valid", vec_valid, 0);
      chk("mid_sat",       sat,       0);
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rel_ready_low", cnt_ready, 0);
      @(negedge clk);
      chk("mid_rel_ready_high", cnt_ready, 1);
      chk("mid_rel_vec_valid", vec_valid, 0);
      send(3, 80, v);

`ifdef POPCOUNT_UNARY_SHUFFLE_EN
      begin
         int nonthermo = 0;
         do_reset();
         for (int i = 0; i < 1000; i++) begin
            cnts[i] = $urandom_range(10);
            send(cnts[i], 100, v);
            v1[i] = v;
            if (v != thermo(cnts[i])) nonthermo++;
         end
         chk("nonthermo_seen", (nonthermo > 0), 1);
         do_reset();
         for (int i = 0; i < 1000; i++) begin
            send(cnts[i], ($urandom_range(1) != 0) ? 100 : 70, v);
            chk("reseed_repeat", v, v1[i]);
         end
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
